// File: rtl/aes_block_gearbox.sv
// aes_block_gearbox: packs 32-bit words into 128-bit AES blocks and unpacks
// 128-bit results back into 32-bit words, one block in flight at a time.
module aes_block_gearbox #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [31:0]      in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [127:0]     blk_data_o,
  output logic             blk_valid_o,
  input  logic             blk_ready_i,
  input  logic [127:0]     res_data_i,
  input  logic             res_valid_i,
  output logic [31:0]      out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] blk_count_o
);
  typedef enum logic [1:0] {FILL, ISSUE, WAIT_RES, DRAIN} state_t;
  state_t state;
  logic [1:0] in_idx, out_idx;
  // element 3 holds bits [127:96], so word k lives at element ~k
  logic [3:0][31:0] in_buf, out_buf;
  logic [CNT_W-1:0] blk_count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= FILL;
      in_idx    <= '0;
      out_idx   <= '0;
      in_buf    <= '0;
      out_buf   <= '0;
      blk_count <= '0;
    end else if (clear) begin
      state     <= FILL;
      in_idx    <= '0;
      out_idx   <= '0;
      in_buf    <= '0;
      out_buf   <= '0;
      blk_count <= '0;
    end else begin
      case (state)
        FILL:
          if (in_valid_i) begin
            in_buf[~in_idx] <= in_data_i;
            in_idx <= in_idx + 2'd1;
            if (in_idx == 2'd3 || flush_i) begin
              state  <= ISSUE;
              in_idx <= '0;
            end
          end else if (flush_i && in_idx != 2'd0) begin
            state  <= ISSUE;
            in_idx <= '0;
          end
        ISSUE:
          if (blk_ready_i) state <= WAIT_RES;
        WAIT_RES:
          if (res_valid_i) begin
            out_buf <= res_data_i;
            state   <= DRAIN;
          end
        DRAIN:
          if (out_ready_i) begin
            out_idx <= out_idx + 2'd1;
            if (out_idx == 2'd3) begin
              state     <= FILL;
              in_buf    <= '0;
              blk_count <= blk_count + 1'b1;
            end
          end
        default: state <= FILL;
      endcase
    end
  assign in_ready_o  = state == FILL;
  assign blk_valid_o = state == ISSUE;
  assign out_valid_o = state == DRAIN;
  assign blk_data_o  = in_buf;
  assign out_data_o  = out_buf[~out_idx];
  assign busy_o      = !(state == FILL && in_idx == 2'd0);
  assign blk_count_o = blk_count;
endmodule

// File: doc/aes_block_gearbox.md
AES_BLOCK_GEARBOX -- requirements
Module: aes_block_gearbox

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-block counter.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clear  input  1  synchronous clear from the control FSM.
REQ-005 SHALL have port in_data_i  input  32  input word from the source streamer.
REQ-006 SHALL have port in_valid_i  input  1  input word valid.
REQ-007 SHALL have port in_ready_o  output  1  input word accepted when high together with in_valid_i.
REQ-008 SHALL have port flush_i  input  1  pad the partial block with zeros and issue it.
REQ-009 SHALL have port blk_data_o  output  128  packed block to the AES core.
REQ-010 SHALL have port blk_valid_o  output  1  block valid to the core.
REQ-011 SHALL have port blk_ready_i  input  1  core accepts block.
REQ-012 SHALL have port res_data_i  input  128  core result block.
REQ-013 SHALL have port res_valid_i  input  1  core result valid (single-cycle pulse).
REQ-014 SHALL have port out_data_o  output  32  result word to the sink streamer.
REQ-015 SHALL have port out_valid_o  output  1  result word valid.
REQ-016 SHALL have port out_ready_i  input  1  sink accepts word.
REQ-017 SHALL have port busy_o  output  1  high in every state except FILL with zero words held.
REQ-018 SHALL have port blk_count_o  output  CNT_W  number of blocks fully drained.

Function
REQ-019 SHALL implement states FILL, ISSUE, WAIT_RES, DRAIN; handshakes complete only when valid and ready are both high in the same cycle.
REQ-020 In FILL, in_ready_o SHALL be 1; all other states 0.
REQ-021 Accepted word k (k = 0..3, 2-bit in_idx) SHALL be written to blk bits [127-32k : 96-32k]; word 0 is most significant.
REQ-022 Acceptance of word 3 in cycle N SHALL move to ISSUE with blk_valid_o = 1 in cycle N+1; in_idx wraps to 0.
REQ-023 flush_i in FILL with in_idx > 0 SHALL move to ISSUE; unwritten words remain zero.
REQ-024 flush_i in FILL with in_idx = 0 and no word accepted that cycle SHALL be ignored.
REQ-025 flush_i coincident with an accepted word SHALL capture that word first, then issue the block.
REQ-026 flush_i outside FILL SHALL be ignored.
REQ-027 In ISSUE, blk_valid_o SHALL be 1 and blk_data_o SHALL be stable until blk_ready_i; then the block moves to WAIT_RES.
REQ-028 In WAIT_RES, res_valid_i SHALL capture res_data_i into the output buffer and move to DRAIN; out_valid_o = 1 the next cycle.
REQ-029 res_valid_i in any state other than WAIT_RES SHALL be ignored.
REQ-030 In DRAIN, out_data_o SHALL be word out_idx of the result (word 0 = [127:96]) and out_valid_o SHALL be 1; out_data_o is stable while out_ready_i is low.
REQ-031 Acceptance of output word 3 SHALL return to FILL, zero the input buffer, and increment blk_count_o.
REQ-032 blk_count_o SHALL wrap from 2^CNT_W-1 to 0.
REQ-033 A padded block SHALL still drain all 4 output words.
REQ-034 clear SHALL have priority over all events: state FILL, in_idx/out_idx 0, buffers 0, blk_count_o 0, effective next cycle.

Reset
REQ-035 On reset_n low, all of the following SHALL apply immediately and asynchronously: state FILL, in_idx/out_idx 0, input/output buffers 0, blk_count_o 0.
REQ-036 On reset_n low, the outputs SHALL be: in_ready_o = 1, blk_valid_o = 0, out_valid_o = 0, busy_o = 0, blk_data_o = 0, out_data_o = 0.
REQ-037 Reset asserted mid-block SHALL discard all held data with no output activity after release.

Verification
REQ-038 Full block: words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF -> blk_data_o = 0x00112233_44556677_8899AABB_CCDDEEFF with blk_valid_o high the cycle after word 3.
REQ-039 Loopback: res_data_i = blk_data_o, out_ready_i held 1 -> out words emerge in order 0x00112233..0xCCDDEEFF on 4 consecutive cycles, and blk_count_o = 1.
REQ-040 Flush: 2 words 0xA, 0xB then flush_i -> blk_data_o = 0x0000000A_0000000B_00000000_00000000, and 4 output words drained.
REQ-041 Backpressure: blk_ready_i low for 5 cycles, then out_ready_i toggling -> data stable and no word lost or duplicated.
REQ-042 Counter wrap with CNT_W = 2: after 4 blocks -> blk_count_o = 0; res_valid_i pulsed in FILL -> no out_valid_o.
REQ-043 Clear in DRAIN after 2 output words -> next cycle FILL, out_valid_o = 0, and blk_count_o = 0.
